// File: rtl/mdu_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
package mdu_pkg;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } state_e;

endpackage

// File: rtl/mdu_cond_neg.sv
// Combinational conditional two's-complement negation.
module mdu_cond_neg #(
    parameter int unsigned W = 32
) (
    input  logic         neg,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout_c
);

    assign dout_c = neg ? (~din + W'(1)) : din;

endmodule

// File: rtl/mul_div_unit.sv
// Iterative shift-add multiplier / restoring divider with HI/LO result registers.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_lo_q, neg_lo_d;
    logic             neg_hi_q, neg_hi_d;
    logic             is_div_q, is_div_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic             signed_op_c;
    logic [WIDTH-1:0] abs_a_c, abs_b_c;
    logic [W2-1:0]    fix_full_c;
    logic [WIDTH-1:0] fix_rem_c;
    logic [WIDTH:0]   mul_sum_c;
    logic [WIDTH:0]   div_shift_c;
    logic [WIDTH:0]   div_diff_c;
    logic             q_bit_c;
    logic [WIDTH-1:0] rem_new_c;

    assign signed_op_c = (op == OP_MULT) || (op == OP_DIV);

    mdu_cond_neg #(.W(WIDTH)) u_abs_a (
        .neg    (signed_op_c & rs[WIDTH-1]),
        .din    (rs),
        .dout_c (abs_a_c)
    );

    mdu_cond_neg #(.W(WIDTH)) u_abs_b (
        .neg    (signed_op_c & rt[WIDTH-1]),
        .din    (rt),
        .dout_c (abs_b_c)
    );

    // Full-width fix serves the product; its low half is also the negated quotient.
    mdu_cond_neg #(.W(W2)) u_fix_full (
        .neg    (neg_lo_q),
        .din    (acc_q),
        .dout_c (fix_full_c)
    );

    mdu_cond_neg #(.W(WIDTH)) u_fix_rem (
        .neg    (neg_hi_q),
        .din    (acc_q[W2-1:WIDTH]),
        .dout_c (fix_rem_c)
    );

    // Datapath step terms: acc = {upper, lower}; lower holds multiplier/quotient bits.
    assign mul_sum_c   = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign div_shift_c = acc_q[W2-1:WIDTH-1];
    assign div_diff_c  = div_shift_c - {1'b0, b_q};
    assign q_bit_c     = (div_shift_c >= {1'b0, b_q});
    assign rem_new_c   = q_bit_c ? div_diff_c[WIDTH-1:0] : div_shift_c[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        is_div_d = is_div_q;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dbz_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            acc_d    = {{WIDTH{1'b0}}, abs_a_c};
                            b_d      = abs_b_c;
                            is_div_d = (op == OP_DIV) || (op == OP_DIVU);
                            neg_lo_d = signed_op_c & (rs[WIDTH-1] ^ rt[WIDTH-1]);
                            neg_hi_d = signed_op_c & rs[WIDTH-1] & is_div_d;
                            dz_d     = is_div_d && (rt == '0);
                            cnt_d    = CNT_W'(WIDTH);
                            busy_d   = 1'b1;
                            state_d  = is_div_d ? ST_DIV : ST_MUL;
                        end
                        OP_MTHI: hi_d = rs;
                        OP_MTLO: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                acc_d = {mul_sum_c, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_DIV: begin
                acc_d = {rem_new_c, acc_q[WIDTH-2:0], q_bit_c};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div_q) begin
                    lo_d  = dz_q ? {WIDTH{1'b1}} : fix_full_c[WIDTH-1:0];
                    hi_d  = fix_rem_c;
                    dbz_d = dz_q;
                end else begin
                    {hi_d, lo_d} = fix_full_c;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            is_div_q <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            is_div_q <= is_div_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: 32-bit and 8-bit instances on one clock.
module tb_mul_div_unit;
    import mdu_pkg::*;

    logic        clock;
    logic        reset_n;

    logic        start32;
    logic [2:0]  op32;
    logic [31:0] rs32, rt32, hi32, lo32;
    logic        busy32, done32, dbz32;

    logic        start8;
    logic [2:0]  op8;
    logic [7:0]  rs8, rt8, hi8, lo8;
    logic        busy8, done8, dbz8;

    int total;
    int bad;

    mul_div_unit #(.WIDTH(32)) u_dut32 (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start32),
        .op          (op32),
        .rs          (rs32),
        .rt          (rt32),
        .busy        (busy32),
        .done        (done32),
        .div_by_zero (dbz32),
        .hi          (hi32),
        .lo          (lo32)
    );

    mul_div_unit #(.WIDTH(8)) u_dut8 (
        .clock       (clock),
        .reset_n     (reset_n),
        .start       (start8),
        .op          (op8),
        .rs          (rs8),
        .rt          (rt8),
        .busy        (busy8),
        .done        (done8),
        .div_by_zero (dbz8),
        .hi          (hi8),
        .lo          (lo8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Drive a request for one cycle starting at a falling edge; returns at the next falling edge.
    task automatic issue(input bit w8, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            start8 = 1'b1; op8 = o; rs8 = a[7:0]; rt8 = b[7:0];
        end else begin
            start32 = 1'b1; op32 = o; rs32 = a; rt32 = b;
        end
        @(negedge clock);
        start8  = 1'b0;
        start32 = 1'b0;
        op8     = OP_NOP;
        op32    = OP_NOP;
    endtask

    task automatic wait_done(input bit w8, output int edges, output int busy_cyc, output logic dbz);
        edges    = 0;
        busy_cyc = 0;
        dbz      = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clock);
            if (w8 ? done8 : done32) begin
                edges = n;
                dbz   = w8 ? dbz8 : dbz32;
                break;
            end
            if (w8 ? busy8 : busy32) busy_cyc++;
        end
    endtask

    task automatic run32(input string tag, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dbz);
        int   edges;
        int   bc;
        logic dbz;
        issue(1'b0, o, a, b);
        wait_done(1'b0, edges, bc, dbz);
        chk({tag, "_latency"}, 64'(edges), 64'd33);
        chk({tag, "_busy_cycles"}, 64'(bc), 64'd32);
        chk({tag, "_hi"}, 64'(hi32), 64'(exp_hi));
        chk({tag, "_lo"}, 64'(lo32), 64'(exp_lo));
        chk({tag, "_dbz"}, 64'(dbz), 64'(exp_dbz));
    endtask

    initial begin
        int   edges;
        int   bc;
        logic dbz;
        logic seen_done;

        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        start32 = 1'b0; op32 = OP_NOP; rs32 = '0; rt32 = '0;
        start8  = 1'b0; op8  = OP_NOP; rs8  = '0; rt8  = '0;

        repeat (2) @(negedge clock);
        chk("rst_hi", 64'(hi32), 64'd0);
        chk("rst_lo", 64'(lo32), 64'd0);
        chk("rst_busy", 64'(busy32), 64'd0);
        chk("rst_done", 64'({done32, dbz32}), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);

        run32("mult_neg", OP_MULT, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b0);
        @(negedge clock);
        chk("mult_done_once", 64'(done32), 64'd0);

        run32("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run32("div_neg7", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run32("divu_7", OP_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 1'b0);

        // Request in the done cycle is accepted because the unit is already idle.
        issue(1'b0, OP_MTLO, 32'h0000_1234, 32'd0);
        chk("done_cycle_mtlo_lo", 64'(lo32), 64'h1234);
        chk("done_cycle_mtlo_hi", 64'(hi32), 64'd1);

        run32("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run32("divu_zero", OP_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
        run32("div_zero_neg", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

        // Requests while busy are dropped, MTHI included.
        issue(1'b0, OP_MULT, 32'd3, 32'd4);
        repeat (3) @(negedge clock);
        start32 = 1'b1; op32 = OP_MULT; rs32 = 32'd7; rt32 = 32'd7;
        @(negedge clock);
        op32 = OP_MTHI; rs32 = 32'h0000_DEAD;
        @(negedge clock);
        start32 = 1'b0; op32 = OP_NOP;
        wait_done(1'b0, edges, bc, dbz);
        chk("ignore_latency", 64'(edges), 64'd28);
        chk("ignore_hi", 64'(hi32), 64'd0);
        chk("ignore_lo", 64'(lo32), 64'd12);
        repeat (3) @(negedge clock);
        chk("ignore_no_queue", 64'(busy32), 64'd0);
        chk("hold_lo", 64'(lo32), 64'd12);

        issue(1'b0, OP_MTHI, 32'h0000_A5A5, 32'd0);
        chk("mthi_hi", 64'(hi32), 64'hA5A5);
        chk("mthi_no_done", 64'(done32), 64'd0);

        // Asynchronous reset mid-operation, applied away from any rising edge.
        issue(1'b0, OP_MULTU, 32'h0000_1234, 32'h10);
        repeat (9) @(negedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_busy", 64'(busy32), 64'd0);
        chk("abort_hi", 64'(hi32), 64'd0);
        chk("abort_lo", 64'(lo32), 64'd0);
        @(negedge clock);
        reset_n   = 1'b1;
        seen_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (done32) seen_done = 1'b1;
        end
        chk("abort_no_done", 64'(seen_done), 64'd0);
        chk("abort_lo_stays", 64'(lo32), 64'd0);

        // Narrow instance.
        issue(1'b1, OP_MULT, 32'h80, 32'h80);
        wait_done(1'b1, edges, bc, dbz);
        chk("w8_latency", 64'(edges), 64'd9);
        chk("w8_busy_cycles", 64'(bc), 64'd8);
        chk("w8_hi", 64'(hi8), 64'h40);
        chk("w8_lo", 64'(lo8), 64'h00);
        issue(1'b1, OP_MTLO, 32'h5A, 32'd0);
        chk("w8_mtlo_lo", 64'(lo8), 64'h5A);
        chk("w8_mtlo_no_done", 64'(done8), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
